piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter: the sending end of the team's serial-in shift register link. Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first, one bit per Shift_en tick. After WIDTH samples, the first bit sent sits in the receiver's top bit. A one-word holding buffer allows back-to-back words with no idle gap.

Parameters:
WIDTH, 4, word width in bits; must be at least 2.
IDLE_LEVEL, 1'b0, Serial_out level when no word is shifting.
CNT_W, $clog2(WIDTH), derived localparam giving the bit counter width; not overridable.

Ports:
CLK  input  1  single clock; all state changes on its rising edge.
Reset  input  1  asynchronous, active-high reset.
Data_in  input  WIDTH  parallel word to send.
Load_valid  input  1  Data_in is valid.
Load_ready  output  1  holding buffer can accept a word.
Shift_en  input  1  bit-rate tick; shifting advances only on edges where it is 1.
Serial_out  output  1  serial data, MSB first.
Bit_valid  output  1  high while a word is on Serial_out (state SHIFT).
Busy  output  1  SHIFT state, or holding buffer full.
Done  output  1  one-cycle pulse when a word's last bit period ends.

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE, shreg=0, cnt=0, hold_full=0, Serial_out=IDLE_LEVEL, Bit_valid=0, Busy=0, Done=0, Load_ready=0 while Reset is high and 1 after release.
- All outputs are decoded from registers only. There is no combinational path from any input to any output.
- Accept: transfer occurs on an edge with Load_valid=1 and Load_ready=1. Then hold_data<=Data_in and hold_full<=1.
- Load_ready = !hold_full. A drain on the same edge does not raise ready early.
- States are IDLE and SHIFT.
- IDLE, with hold_full=1 and Shift_en=1: shreg<=hold_data, cnt<=0, state<=SHIFT, hold_full cleared.
- IDLE, with Shift_en=0: wait.
- SHIFT, with Shift_en=1 and cnt<WIDTH-1: shreg<=shreg<<1, cnt<=cnt+1.
- SHIFT, with Shift_en=1 and cnt==WIDTH-1: word complete and Done=1 on the next cycle.
  - If hold_full=1: reload shreg from hold_data, cnt<=0, stay in SHIFT (zero-gap back-to-back).
  - Otherwise: go to IDLE.
- Serial_out = shreg[WIDTH-1] in SHIFT, IDLE_LEVEL in IDLE. Each bit is held for one full Shift_en interval.
- Latency: with Shift_en=1, a word accepted at edge k shows its MSB after edge k+1. The last bit is visible after edge k+WIDTH. Done pulses after edge k+WIDTH+1.
- Simultaneous accept and drain (hold_full=0 at the edge and the shifter reloads from hold): impossible by the ready rule.
- Accept on an edge where hold is empty and the shifter is mid-word: the word waits in hold.
- Reset mid-word discards both the shifting and the held word. No Done is produced.
- Shift_en is ignored in IDLE when hold is empty. Shift_en does not gate the handshake.

Decomposition:
- Shared package serial_pkg holds:
  - state encoding localparams ST_IDLE and ST_SHIFT;
  - default word width SER_WIDTH=4;
  - IDLE_LEVEL default.
- One natural sub-module, serial_hold_buf: the one-entry holding register with valid/ready. It has ports CLK, Reset, Data_in, Load_valid, Load_ready, pop, hold_data, hold_full.

Test Plan:
1. Reset pulse mid-cycle (async), then idle with Shift_en=1 -> Serial_out=0, Bit_valid=0, Busy=0, Done=0, Load_ready=1 after release.
2. WIDTH=4, Shift_en=1, send 4'b1011 accepted at edge 0 -> Serial_out 1,0,1,1 after edges 1-4; Done=1 only after edge 5; then IDLE with Serial_out=0.
3. Back-to-back 4'hA then 4'h5, Load_valid held -> continuous stream 1010_0101 with Bit_valid never dropping; Load_ready=0 while hold is full; two Done pulses, 4 cycles apart.
4. Shift_en asserted every 3rd cycle, word 4'b1100 -> each bit held 3 cycles; word occupies 12 cycles; no shift on Shift_en=0 edges.
5. Loopback into the team's 4-bit serial-in register (same CLK, Shift_en=1), send 4'b1011 -> after its edges 2-5 sample Serial_out, Bit_3..Bit_0 = 1,0,1,1.
6. Assert Reset after 2 bits of 4'h9 while 4'h3 is held -> immediate Serial_out=0, Busy=0, no Done; after release, send 4'h6 -> clean 0,1,1,0 with one Done.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial shift-register link: word width default,
// idle line level and the transmitter state encoding.
package serial_pkg;

  localparam int   SER_WIDTH      = 4;
  localparam logic SER_IDLE_LEVEL = 1'b0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel-load handshake plus serial line of the transmitter. The master
// side supplies words and the bit-rate tick; the slave side is the serializer.
interface piso_serializer_if
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) ();

  logic [WIDTH-1:0] Data_in;
  logic             Load_valid;
  logic             Load_ready;
  logic             Shift_en;
  logic             Serial_out;
  logic             Bit_valid;
  logic             Busy;
  logic             Done;

  modport master (
    output Data_in, Load_valid, Shift_en,
    input  Load_ready, Serial_out, Bit_valid, Busy, Done
  );

  modport slave (
    input  Data_in, Load_valid, Shift_en,
    output Load_ready, Serial_out, Bit_valid, Busy, Done
  );

endinterface

// File: rtl/piso_serializer_chk.sv
// Output-level invariants of the serializer: idle line level, busy coverage
// of the shifting state and single-cycle done pulses.
module piso_serializer_chk
  import serial_pkg::*;
#(
  parameter logic IDLE_LEVEL = SER_IDLE_LEVEL
) (
  input logic CLK,
  input logic Reset,
  input logic Serial_out,
  input logic Bit_valid,
  input logic Busy,
  input logic Done
);

  a_idle_level: assert property (@(posedge CLK) disable iff (Reset)
    !Bit_valid |-> (Serial_out == IDLE_LEVEL));

  a_busy_covers_shift: assert property (@(posedge CLK) disable iff (Reset)
    Bit_valid |-> Busy);

  a_done_single: assert property (@(posedge CLK) disable iff (Reset)
    Done |=> !Done);

endmodule

// File: rtl/serial_hold_buf.sv
// One-entry holding register with valid/ready on the load side and a pop
// strobe from the shifter. Ready is registered and mirrors "hold empty".
module serial_hold_buf
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Data_in,
  input  logic             Load_valid,
  output logic             Load_ready,
  input  logic             pop,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_full
);

  logic             hold_full_r;
  logic             hold_full_next_s;
  logic             ready_r;
  logic             accept_s;
  logic [WIDTH-1:0] hold_data_r;

  assign accept_s = Load_valid && ready_r;

  // Occupancy update; accept and pop never coincide because ready implies empty.
  always_comb begin
    hold_full_next_s = hold_full_r;
    if (accept_s) begin
      hold_full_next_s = 1'b1;
    end else if (pop) begin
      hold_full_next_s = 1'b0;
    end else begin
      hold_full_next_s = hold_full_r;
    end
  end

  // Holding register, occupancy flag and registered ready.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      hold_full_r <= 1'b0;
      ready_r     <= 1'b0;
      hold_data_r <= {WIDTH{1'b0}};
    end else begin
      hold_full_r <= hold_full_next_s;
      ready_r     <= !hold_full_next_s;
      if (accept_s) begin
        hold_data_r <= Data_in;
      end
    end
  end

  assign Load_ready = ready_r;
  assign hold_data  = hold_data_r;
  assign hold_full  = hold_full_r;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: MSB-first, one bit per Shift_en tick,
// with a one-word holding buffer for gapless back-to-back words.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int   WIDTH      = SER_WIDTH,
  parameter logic IDLE_LEVEL = SER_IDLE_LEVEL
) (
  input  logic               CLK,
  input  logic               Reset,
  piso_serializer_if.slave   bus
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_t       state_r;
  ser_state_t       state_next_s;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] shreg_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             done_r;
  logic             done_next_s;
  logic             pop_s;
  logic             hold_full_s;
  logic             load_ready_s;
  logic [WIDTH-1:0] hold_data_s;

  serial_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold (
    .CLK        (CLK),
    .Reset      (Reset),
    .Data_in    (bus.Data_in),
    .Load_valid (bus.Load_valid),
    .Load_ready (load_ready_s),
    .pop        (pop_s),
    .hold_data  (hold_data_s),
    .hold_full  (hold_full_s)
  );

  // Next-state, shifter and done decode.
  always_comb begin
    state_next_s = state_r;
    shreg_next_s = shreg_r;
    cnt_next_s   = cnt_r;
    done_next_s  = 1'b0;
    pop_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (hold_full_s && bus.Shift_en) begin
          shreg_next_s = hold_data_s;
          cnt_next_s   = CNT_ZERO;
          state_next_s = ST_SHIFT;
          pop_s        = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bus.Shift_en) begin
          if (cnt_r == CNT_LAST) begin
            done_next_s = 1'b1;
            // A waiting word follows with no idle bit period in between.
            if (hold_full_s) begin
              shreg_next_s = hold_data_s;
              cnt_next_s   = CNT_ZERO;
              pop_s        = 1'b1;
            end else begin
              state_next_s = ST_IDLE;
            end
          end else begin
            shreg_next_s = {shreg_r[WIDTH-2:0], 1'b0};
            cnt_next_s   = cnt_r + CNT_ONE;
          end
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, shifter, bit counter and done pulse registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      shreg_r <= {WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      shreg_r <= shreg_next_s;
      cnt_r   <= cnt_next_s;
      done_r  <= done_next_s;
    end
  end

  assign bus.Serial_out = (state_r == ST_SHIFT) ? shreg_r[WIDTH-1] : IDLE_LEVEL;
  assign bus.Bit_valid  = (state_r == ST_SHIFT);
  assign bus.Busy       = (state_r == ST_SHIFT) || hold_full_s;
  assign bus.Done       = done_r;
  assign bus.Load_ready = load_ready_s;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed latency/handshake scenarios plus random
// traffic checked against a bit-queue reference model.
module tb_piso_serializer;
  import serial_pkg::*;

  localparam int W = 4;

  logic CLK   = 1'b0;
  logic Reset = 1'b0;
  always #5 CLK = ~CLK;

  piso_serializer_if #(.WIDTH(W)) bus ();

  piso_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  piso_serializer_chk #(.IDLE_LEVEL(1'b0)) u_chk (
    .CLK        (CLK),
    .Reset      (Reset),
    .Serial_out (bus.Serial_out),
    .Bit_valid  (bus.Bit_valid),
    .Busy       (bus.Busy),
    .Done       (bus.Done)
  );

  // Receiving shift register of the link, used for the loopback scenario.
  logic [W-1:0] sipo = '0;
  always @(posedge CLK) if (bus.Shift_en) sipo <= {sipo[W-2:0], bus.Serial_out};

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: bits still owed on the line, words in flight, bits sent.
  logic exp_bits[$];
  int   in_sys    = 0;
  int   bits_done = 0;

  task automatic model_clear();
    exp_bits.delete();
    in_sys    = 0;
    bits_done = 0;
  endtask

  // One clock: capture what the edge will see, advance, then score the edge.
  task automatic tick(output logic acc);
    logic         p_acc, p_cons, p_so, done_exp;
    logic [W-1:0] p_word;
    p_acc  = bus.Load_valid && bus.Load_ready;
    p_word = bus.Data_in;
    p_cons = bus.Shift_en && bus.Bit_valid;
    p_so   = bus.Serial_out;
    @(posedge CLK);
    #1;
    acc = p_acc && !Reset;
    if (!Reset) begin
      if (p_acc) begin
        for (int i = W - 1; i >= 0; i--) exp_bits.push_back(p_word[i]);
        in_sys++;
      end
      done_exp = 1'b0;
      if (p_cons) begin
        if (exp_bits.size() == 0) chk("stray_bit", exp_bits.size(), 1);
        else chk("bit", p_so, exp_bits.pop_front());
        bits_done++;
        if (bits_done % W == 0) begin
          done_exp = 1'b1;
          in_sys--;
        end
      end
      chk("done", bus.Done, done_exp);
      chk("busy", bus.Busy, in_sys > 0);
      if (in_sys == 2) chk("ready_full", bus.Load_ready, 1'b0);
      if (in_sys == 0) begin
        chk("ready_empty", bus.Load_ready, 1'b1);
        chk("idle_bv", bus.Bit_valid, 1'b0);
        chk("idle_so", bus.Serial_out, 1'b0);
      end
    end
  endtask

  task automatic send_word(input logic [W-1:0] w);
    logic a;
    logic got = 1'b0;
    bus.Data_in    = w;
    bus.Load_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(a);
      got = a;
    end
    bus.Load_valid = 1'b0;
    chk("accept_timeout", got, 1'b1);
  endtask

  logic         a;
  logic [7:0]   stream;
  logic [11:0]  pat;
  logic [W-1:0] w6;
  int           d0, d1, nd, bvcnt;

  initial begin
    bus.Data_in    = '0;
    bus.Load_valid = 1'b0;
    bus.Shift_en   = 1'b1;

    // 1: asynchronous reset mid-cycle, then idle
    #3 Reset = 1'b1;
    #1;
    chk("rst_so", bus.Serial_out, 1'b0);
    chk("rst_bv", bus.Bit_valid, 1'b0);
    chk("rst_busy", bus.Busy, 1'b0);
    chk("rst_done", bus.Done, 1'b0);
    chk("rst_ready", bus.Load_ready, 1'b0);
    @(negedge CLK);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) tick(a);
    chk("t1_ready", bus.Load_ready, 1'b1);
    chk("t1_busy", bus.Busy, 1'b0);

    // 2: single word latency
    send_word(4'b1011);
    for (int i = 0; i < W; i++) begin
      tick(a);
      w6 = 4'b1011;
      chk("t2_so", bus.Serial_out, w6[W-1-i]);
      chk("t2_bv", bus.Bit_valid, 1'b1);
    end
    tick(a);
    chk("t2_done", bus.Done, 1'b1);
    chk("t2_idle", bus.Bit_valid, 1'b0);
    tick(a);
    chk("t2_done_end", bus.Done, 1'b0);

    // 3: back-to-back words with Load_valid held
    d0 = -1; d1 = -1; nd = 0; stream = '0;
    bus.Data_in = 4'hA;
    bus.Load_valid = 1'b1;
    w6 = 4'hA;
    for (int c = 0; c < 12; c++) begin
      tick(a);
      if (a) begin
        if (w6 == 4'hA) begin w6 = 4'h5; bus.Data_in = 4'h5; end
        else bus.Load_valid = 1'b0;
      end
      if (c == 0 || c == 2) chk("t3_ready_full", bus.Load_ready, 1'b0);
      if (c >= 1 && c <= 8) begin
        stream = {stream[6:0], bus.Serial_out};
        chk("t3_bv", bus.Bit_valid, 1'b1);
      end
      if (bus.Done) begin
        if (nd == 0) d0 = c; else d1 = c;
        nd++;
      end
    end
    bus.Load_valid = 1'b0;
    chk("t3_stream", stream, 8'hA5);
    chk("t3_ndone", nd, 2);
    chk("t3_done0", d0, 5);
    chk("t3_gap", d1 - d0, W);

    // 4: Shift_en every third cycle
    bus.Shift_en = 1'b0;
    send_word(4'b1100);
    bvcnt = 0; pat = '0;
    for (int c = 0; c < 30; c++) begin
      bus.Shift_en = (c % 3 == 0);
      tick(a);
      if (bus.Bit_valid) begin
        bvcnt++;
        pat = {pat[10:0], bus.Serial_out};
      end
    end
    bus.Shift_en = 1'b1;
    chk("t4_len", bvcnt, 12);
    chk("t4_pattern", pat, 12'hFC0);

    // 5: loopback into the receiving register
    send_word(4'b1011);
    for (int i = 0; i < 5; i++) tick(a);
    chk("t5_sipo", sipo, 4'b1011);
    tick(a);

    // 6: reset mid-word with a word held
    send_word(4'h9);
    bus.Data_in = 4'h3;
    bus.Load_valid = 1'b1;
    tick(a);
    tick(a);
    chk("t6_acc", a, 1'b1);
    bus.Load_valid = 1'b0;
    tick(a);
    #2 Reset = 1'b1;
    #1;
    chk("t6_so", bus.Serial_out, 1'b0);
    chk("t6_busy", bus.Busy, 1'b0);
    chk("t6_bv", bus.Bit_valid, 1'b0);
    chk("t6_done", bus.Done, 1'b0);
    @(posedge CLK);
    #1;
    chk("t6_done_rst", bus.Done, 1'b0);
    Reset = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) tick(a);
    send_word(4'h6);
    nd = 0; w6 = '0;
    for (int i = 0; i < 6; i++) begin
      tick(a);
      if (i < W) w6 = {w6[W-2:0], bus.Serial_out};
      if (bus.Done) nd++;
    end
    chk("t6_word", w6, 4'h6);
    chk("t6_ndone", nd, 1);

    // Random traffic against the model, then drain
    for (int c = 0; c < 600; c++) begin
      bus.Shift_en   = ($urandom_range(0, 2) != 0);
      bus.Load_valid = $urandom_range(0, 1) == 1;
      bus.Data_in    = W'($urandom);
      tick(a);
    end
    bus.Load_valid = 1'b0;
    bus.Shift_en   = 1'b1;
    for (int c = 0; c < 40 && in_sys > 0; c++) tick(a);
    chk("drain_words", in_sys, 0);
    chk("drain_bits", exp_bits.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
